alu_exec_unit: RTL
==================

# alu_exec_unit

Multi-cycle execute stage that sits directly in front of `register_file` (16 × 16-bit, two combinational read ports, one synchronous write port). It accepts one three-register instruction per valid/ready handshake and reads both source operands through `raddr1`/`raddr2`. It computes the ALU result and writes it back through `waddr`/`wdata`/`wen`. It also reports the result and flags to the sequencer upstream.

## Interface
- `DATA_W`, 16, register/data width (matches `register_file`)
- `ADDR_W`, 4, register address width (16 registers)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  instruction present
- `in_ready`  out  1  unit can accept (high only in IDLE)
- `in_op`  in  3  opcode
- `in_rd`  in  ADDR_W  destination register
- `in_rs1`  in  ADDR_W  source 1 (imm[7:4] for LDI)
- `in_rs2`  in  ADDR_W  source 2 (imm[3:0] for LDI)
- `raddr1`  out  ADDR_W  to register_file
- `raddr2`  out  ADDR_W  to register_file
- `rdata1`  in  DATA_W  from register_file (combinational)
- `rdata2`  in  DATA_W  from register_file (combinational)
- `waddr`  out  ADDR_W  write-back address
- `wdata`  out  DATA_W  write-back data
- `wen`  out  1  write-back strobe, one cycle
- `done`  out  1  one-cycle pulse, coincident with `wen`
- `result`  out  DATA_W  last written value, held
- `zero`  out  1  `result == 0`, held
- `carry`  out  1  carry/borrow of last op, held

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE. There are no other transitions.
- IDLE: `in_ready`=1. When `in_valid & in_ready` is high at a rising edge, the unit latches op, rd, rs1 and rs2, then moves to READ. If `in_valid`=0, it stays in IDLE.
- READ: `raddr1`=rs1 and `raddr2`=rs2 are driven from the latched registers. `rdata1`/`rdata2` are captured into operand registers A/B at the end of the cycle.
- EXEC: the ALU output and flags are registered into `result`/`zero`/`carry` at the end of the cycle.
- WB: `wen`=1, `waddr`=rd, `wdata`=`result`, `done`=1 for exactly one cycle. The write to `register_file` takes effect at the end of WB.
- Opcode encodings:
  - 000 ADD: A+B, `carry` = bit DATA_W of the sum.
  - 001 SUB: A−B, `carry` = borrow (A<B unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A << B[3:0].
  - 110 SHR: A >> B[3:0], logical.
  - 111 LDI: result = zero-extended {rs1,rs2}. Operands are ignored, but READ is still executed.
- `carry`=0 for all ops except ADD and SUB. Arithmetic is unsigned and modulo 2^DATA_W.
- `rd`=0 is an ordinary register. There is no hardwired zero.
- `raddr1`/`raddr2` hold their last values outside READ. `waddr`/`wdata` hold their values, and `wen`=0, outside WB.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `raddr1`=`raddr2`=0, `waddr`=0, `wdata`=0, `wen`=0, `done`=0, `result`=0, `zero`=0, `carry`=0.
- Latency: the accept edge is followed by READ, EXEC and WB cycles. `wen` is high in the 3rd cycle after the accept edge.
- Throughput: one instruction per 4 cycles when `in_valid` is held high.
- RAW hazard: none. The WB write completes before the next instruction's READ cycle.
- `in_*` inputs are ignored outside IDLE. Upstream must hold them stable only until the accept edge.
- Reset in mid-operation, in any state, has these effects:
  - Asynchronous return to IDLE.
  - `wen`/`done` deassert immediately.
  - The in-flight instruction is dropped with no write.
  - Flags and result are cleared.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `OP_ADD` through `OP_LDI`
  - the FSM state typedef/encodings `S_IDLE`, `S_READ`, `S_EXEC`, `S_WB`
- One combinational sub-module, `alu_core`:
  - inputs: op, A, B, imm
  - outputs: result, carry
- `alu_exec_unit` contains the FSM, the latched instruction fields, the operand registers, the output registers and the `zero` compare.

## Test plan
Bench instantiates `alu_exec_unit` wired to `register_file`.
- Reset: assert `rst` for 2 cycles → all outputs at their reset values and `in_ready`=1. Release `rst` → the unit stays in IDLE with `in_valid`=0.
- LDI r4,0x21 (`in_rs1`=2, `in_rs2`=1) → `wen` pulse 3 cycles after accept with `waddr`=4, `wdata`=0x0021. A direct read of r4 returns 0x0021.
- Shift and ADD overflow, in sequence:
  - LDI r1,0x80
  - LDI r2,0x08
  - SHL r3,r1,r2 → `wdata`=0x8000
  - ADD r5,r3,r3 → `wdata`=0x0000, `zero`=1, `carry`=1
- SUB borrow: SUB r6,r2,r1 → `wdata`=0xFF88, `carry`=1, `zero`=0. SUB r7,r1,r1 → 0x0000, `zero`=1, `carry`=0.
- Back-to-back with `in_valid` held high:
  - LDI r8,0x05
  - then ADD r9,r8,r8
  - Required: accepts exactly 4 cycles apart, and r9=0x000A (dependency resolved).
- Reset during EXEC of ADD r10 → no `wen` ever asserted for r10, r10 keeps its old value, `in_ready`=1 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute stage.
//   - opcode encodings OP_ADD .. OP_LDI (3 bits)
//   - FSM state type state_e (S_IDLE, S_READ, S_EXEC, S_WB)
//   - IMM_W: width of the LDI immediate formed from {rs1, rs2}
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned IMM_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: bundles the instruction handshake, register-file read/write
// ports and the status outputs of alu_exec_unit.
//   slave  : the execute unit (consumes instructions and read data, drives the rest)
//   master : the environment, i.e. the sequencer plus the register file
//            (drives instructions and combinational read data)
interface alu_exec_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              carry;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, rdata1, rdata2,
    input  in_ready, raddr1, raddr2, waddr, wdata, wen, done, result, zero, carry
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, rdata1, rdata2,
    output in_ready, raddr1, raddr2, waddr, wdata, wen, done, result, zero, carry
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   i_op     : opcode (alu_pkg OP_*)
//   i_a, i_b : operands A and B
//   i_imm    : {rs1, rs2} immediate for LDI
//   o_result : ALU result, modulo 2^DATA_W
//   o_carry  : ADD carry-out / SUB borrow, 0 for every other op
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [IMM_W-1:0]  i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [3:0]      w_shamt;

  // One extra bit on each side: the MSB is the carry-out of the add and,
  // for the subtract, it is set exactly when A < B (borrow).
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
  assign w_shamt = i_b[3:0];

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SHL:  o_result = i_a << w_shamt;
      OP_SHR:  o_result = i_a >> w_shamt;
      OP_LDI:  o_result = {{(DATA_W-IMM_W){1'b0}}, i_imm};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: four-phase execute stage in front of a 16-entry register file.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, drops any in-flight instruction
//   bus  : alu_exec_unit_if slave port
//          in_valid/in_ready/in_op/in_rd/in_rs1/in_rs2 - instruction handshake
//          raddr1/raddr2 -> rdata1/rdata2             - operand read (combinational)
//          waddr/wdata/wen                            - write-back, one cycle in WB
//          done/result/zero/carry                     - status to the sequencer
// Sequence: IDLE (accept) -> READ (capture operands) -> EXEC (register result
// and flags) -> WB (write strobe) -> IDLE, i.e. one instruction per 4 cycles.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;

  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_carry;
  logic [ADDR_W-1:0] r_waddr;

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_imm    ({r_rs1, r_rs2}),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction fields are only captured on accept, so the source addresses
  // stay on raddr1/raddr2 through READ and hold until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= OP_ADD;
      r_rd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else if (w_accept) begin
      r_op  <= bus.in_op;
      r_rd  <= bus.in_rd;
      r_rs1 <= bus.in_rs1;
      r_rs2 <= bus.in_rs2;
    end
  end

  // Operand capture at the end of READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (r_state == S_READ) begin
      r_a <= bus.rdata1;
      r_b <= bus.rdata2;
    end
  end

  // Result, flags and write address register at the end of EXEC and hold
  // afterwards; wdata is simply the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_waddr  <= '0;
    end else if (r_state == S_EXEC) begin
      r_result <= w_alu_result;
      r_zero   <= (w_alu_result == '0);
      r_carry  <= w_alu_carry;
      r_waddr  <= r_rd;
    end
  end

  // Strobes decode straight from the state so reset removes them at once.
  always_comb begin
    bus.in_ready = (r_state == S_IDLE);
    bus.wen      = (r_state == S_WB);
    bus.done     = (r_state == S_WB);
    bus.raddr1   = r_rs1;
    bus.raddr2   = r_rs2;
    bus.waddr    = r_waddr;
    bus.wdata    = r_result;
    bus.result   = r_result;
    bus.zero     = r_zero;
    bus.carry    = r_carry;
  end

endmodule
